// File: rtl/colour_sequencer.sv
// Colour-select controller: arbitrates host writes, debounced button advances and
// auto-cycle advances (host > button > auto) into one-cycle strobes for the colour register.
module colour_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned AUTO_PERIOD     = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       auto_en,
  input  logic       host_valid,
  input  logic [1:0] host_colour,
  output logic       host_ready,
  output logic       sel_red,
  output logic       sel_green,
  output logic       sel_blue,
  output logic       sel_yellow,
  output logic [1:0] colour_idx,
  output logic       applied
);

  localparam int unsigned IDX_W = 2;
  localparam int unsigned SEL_W = 4;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_APPLY = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_btn_meta;
  logic               r_btn_s;
  logic               r_btn_stable;
  logic               r_btn_pend;
  logic [CNT_W-1:0]   r_db_cnt;
  logic [CNT_W-1:0]   r_auto_cnt;
  logic [IDX_W-1:0]   r_next_idx;
  logic [IDX_W-1:0]   r_colour_idx;
  logic [SEL_W-1:0]   r_sel;
  logic               r_applied;

  logic               w_btn_diff;
  logic               w_db_done;
  logic               w_btn_rise;
  logic               w_auto_evt;
  logic               w_grant;
  logic               w_btn_take;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [SEL_W-1:0]   w_sel_next;

  // Two-flop synchronizer for the raw push-button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_meta <= 1'b0;
      r_btn_s    <= 1'b0;
    end else begin
      r_btn_meta <= btn_next;
      r_btn_s    <= r_btn_meta;
    end
  end

  assign w_btn_diff = r_btn_s ^ r_btn_stable;
  assign w_db_done  = w_btn_diff && (r_db_cnt == DB_LAST);
  assign w_btn_rise = w_db_done && r_btn_s;

  // Debounce: a level must differ from the accepted one for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt     <= '0;
      r_btn_stable <= 1'b0;
    end else if (!w_btn_diff) begin
      r_db_cnt <= '0;
    end else if (w_db_done) begin
      r_db_cnt     <= '0;
      r_btn_stable <= r_btn_s;
    end else begin
      r_db_cnt <= r_db_cnt + CNT_W'(1);
    end
  end

  // Single-entry pending flag; a new edge on the grant cycle stays pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_pend <= 1'b0;
    end else if (w_btn_rise) begin
      r_btn_pend <= 1'b1;
    end else if (w_btn_take) begin
      r_btn_pend <= 1'b0;
    end
  end

  assign w_auto_evt = (r_state == S_IDLE) && auto_en && (r_auto_cnt == AUTO_LAST);

  // Auto timer counts IDLE cycles only; any APPLY restarts the period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_auto_cnt <= '0;
    end else if ((r_state == S_APPLY) || !auto_en || w_auto_evt) begin
      r_auto_cnt <= '0;
    end else begin
      r_auto_cnt <= r_auto_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Grant arbitration and next-state
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_btn_take   = 1'b0;
    w_grant_idx  = r_colour_idx;
    w_sel_next   = '0;
    case (r_state)
      S_IDLE: begin
        if (host_valid) begin
          w_grant     = 1'b1;
          w_grant_idx = host_colour;
        end else if (r_btn_pend) begin
          w_grant     = 1'b1;
          w_btn_take  = 1'b1;
          w_grant_idx = r_colour_idx + IDX_W'(1);
        end else if (w_auto_evt) begin
          w_grant     = 1'b1;
          w_grant_idx = r_colour_idx + IDX_W'(1);
        end
        if (w_grant) begin
          w_state_next = S_APPLY;
          w_sel_next   = SEL_W'(1) << w_grant_idx;
        end
      end
      S_APPLY: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are registered on the grant edge so they are live for exactly the APPLY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel        <= '0;
      r_applied    <= 1'b0;
      r_next_idx   <= '0;
      r_colour_idx <= '0;
    end else begin
      r_sel     <= w_sel_next;
      r_applied <= w_grant;
      if (w_grant) begin
        r_next_idx <= w_grant_idx;
      end
      if (r_state == S_APPLY) begin
        r_colour_idx <= r_next_idx;
      end
    end
  end

  assign host_ready = (r_state == S_IDLE);
  assign sel_red    = r_sel[0];
  assign sel_green  = r_sel[1];
  assign sel_blue   = r_sel[2];
  assign sel_yellow = r_sel[3];
  assign colour_idx = r_colour_idx;
  assign applied    = r_applied;

endmodule
